delta_ladder_counter: RTL and testbench

Parametrised step counter: each enabled cycle it adds or subtracts a programmable step (delta) to a bounded count.
Three boundary modes are selectable at run time: wrap, saturate and bounce (reflect and reverse direction).
It is the next-generation ladder counting core, generalised in width, step width and range bounds, with load and boundary-event outputs.

---
 rtl/delta_pkg.sv | 14 +
 rtl/delta_step_calc.sv | 79 +++++++
 rtl/delta_ladder_counter.sv | 97 +++++++++
 tb/tb_delta_ladder_counter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/delta_pkg.sv
// Shared types and constants for the delta ladder counter.
package delta_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'b00,
    MODE_SAT    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/delta_step_calc.sv
// Combinational next-count calculation for one enabled step, including the
// wrap / saturate / bounce boundary handling.
module delta_step_calc
  import delta_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int DELTA_W = 3,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic [WIDTH-1:0]   count,
  input  logic [DELTA_W-1:0] delta,
  input  logic               dir,
  input  mode_e              mode,
  output logic [WIDTH-1:0]   next_count,
  output logic               next_dir,
  output logic               overflow
);

  localparam int RW = WIDTH + 2;
  localparam logic signed [RW-1:0] MIN_S     = RW'(MIN_VAL);
  localparam logic signed [RW-1:0] MAX_S     = RW'(MAX_VAL);
  localparam logic signed [RW-1:0] SPAN_S    = RW'(MAX_VAL - MIN_VAL + 1);
  localparam logic signed [RW-1:0] TWO_MIN_S = RW'(2 * MIN_VAL);
  localparam logic signed [RW-1:0] TWO_MAX_S = RW'(2 * MAX_VAL);

  logic signed [RW-1:0] count_s;
  logic signed [RW-1:0] delta_s;
  logic signed [RW-1:0] raw;
  logic signed [RW-1:0] result;
  logic                 unused_hi_bits;

  assign count_s = signed'({2'b00, count});
  assign delta_s = signed'({{(RW-DELTA_W){1'b0}}, delta});
  assign raw     = dir ? (count_s + delta_s) : (count_s - delta_s);

  // A zero step never moves the count or reverses direction, even at a bound.
  always_comb begin
    result   = count_s;
    next_dir = dir;
    overflow = 1'b0;
    if (delta == '0) begin
      result = count_s;
    end else if (raw > MAX_S) begin
      overflow = 1'b1;
      case (mode)
        MODE_WRAP:   result = raw - SPAN_S;
        MODE_BOUNCE: begin
          result   = TWO_MAX_S - raw;
          next_dir = DIR_DOWN;
        end
        default:     result = MAX_S;
      endcase
    end else if (raw < MIN_S) begin
      overflow = 1'b1;
      case (mode)
        MODE_WRAP:   result = raw + SPAN_S;
        MODE_BOUNCE: begin
          result   = TWO_MIN_S - raw;
          next_dir = DIR_UP;
        end
        default:     result = MIN_S;
      endcase
    end else begin
      result = raw;
      if (mode == MODE_BOUNCE) begin
        if ((dir == DIR_UP) && (raw == MAX_S))
          next_dir = DIR_DOWN;
        else if ((dir == DIR_DOWN) && (raw == MIN_S))
          next_dir = DIR_UP;
      end
    end
  end

  // Every result lands inside the count range, so the top two bits are zero.
  assign next_count     = result[WIDTH-1:0];
  assign unused_hi_bits = ^result[RW-1:WIDTH];

endmodule

// File: rtl/delta_ladder_counter.sv
// Bounded step counter: adds or subtracts a programmable delta each enabled
// cycle, with run-time selectable wrap, saturate or bounce boundaries.
module delta_ladder_counter
  import delta_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int DELTA_W = 3,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               en,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [DELTA_W-1:0] delta,
  input  logic               direction,
  input  logic [1:0]         mode,
  output logic [WIDTH-1:0]   count,
  output logic [DELTA_W-1:0] current,
  output logic               dir_q,
  output logic               bound_hit,
  output logic               at_max,
  output logic               at_min
);

  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  if (!((MIN_VAL < MAX_VAL) && (MAX_VAL <= 2**WIDTH-1))) begin : g_bad_range
    $error("delta_ladder_counter: need MIN_VAL < MAX_VAL <= 2**WIDTH-1");
  end
  if ((2**DELTA_W-1) > (MAX_VAL - MIN_VAL)) begin : g_bad_delta
    $error("delta_ladder_counter: largest step must not exceed MAX_VAL-MIN_VAL");
  end

  mode_e            mode_sel;
  logic             step_dir;
  logic [WIDTH-1:0] step_count;
  logic             step_dir_next;
  logic             step_overflow;
  logic [WIDTH-1:0] load_clamped;

  assign mode_sel = mode_e'(mode);

  // Bounce keeps its own travelling direction; the other modes follow the input.
  assign step_dir = (mode_sel == MODE_BOUNCE) ? dir_q : direction;

  delta_step_calc #(
    .WIDTH   (WIDTH),
    .DELTA_W (DELTA_W),
    .MIN_VAL (MIN_VAL),
    .MAX_VAL (MAX_VAL)
  ) u_step_calc (
    .count      (count),
    .delta      (delta),
    .dir        (step_dir),
    .mode       (mode_sel),
    .next_count (step_count),
    .next_dir   (step_dir_next),
    .overflow   (step_overflow)
  );

  always_comb begin
    load_clamped = load_val;
    if (int'(load_val) < MIN_VAL)
      load_clamped = MIN_W;
    else if (int'(load_val) > MAX_VAL)
      load_clamped = MAX_W;
  end

  // Load wins over enable; bound_hit is a one-cycle pulse cleared by any non-step cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count     <= MIN_W;
      current   <= '0;
      dir_q     <= DIR_UP;
      bound_hit <= 1'b0;
    end else if (load) begin
      count     <= load_clamped;
      dir_q     <= direction;
      current   <= '0;
      bound_hit <= 1'b0;
    end else if (en) begin
      count     <= step_count;
      dir_q     <= step_dir_next;
      current   <= delta;
      bound_hit <= step_overflow;
    end else begin
      bound_hit <= 1'b0;
    end
  end

  assign at_max = (count == MAX_W);
  assign at_min = (count == MIN_W);

endmodule

// File: tb/tb_delta_ladder_counter.sv
// Self-checking bench: two counters (bounds 0..15 and 2..12) against an
// arithmetic reference model, plus directed literal checks.
module tb_delta_ladder_counter;

  logic       clk = 1'b0;
  logic       resetn;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  logic [2:0] delta;
  logic       direction;
  logic [1:0] mode;

  logic [3:0] count_a, count_b;
  logic [2:0] current_a, current_b;
  logic       dir_q_a, dir_q_b;
  logic       bound_hit_a, bound_hit_b;
  logic       at_max_a, at_max_b;
  logic       at_min_a, at_min_b;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  check_en = 1'b0;

  typedef struct {
    int count;
    int current;
    bit dir;
    bit hit;
  } mstate_t;

  mstate_t ma, mb;

  always #5 clk = ~clk;

  delta_ladder_counter #(.WIDTH(4), .DELTA_W(3), .MIN_VAL(0), .MAX_VAL(15)) dut_a (
    .clk(clk), .resetn(resetn), .en(en), .load(load), .load_val(load_val),
    .delta(delta), .direction(direction), .mode(mode),
    .count(count_a), .current(current_a), .dir_q(dir_q_a),
    .bound_hit(bound_hit_a), .at_max(at_max_a), .at_min(at_min_a)
  );

  delta_ladder_counter #(.WIDTH(4), .DELTA_W(3), .MIN_VAL(2), .MAX_VAL(12)) dut_b (
    .clk(clk), .resetn(resetn), .en(en), .load(load), .load_val(load_val),
    .delta(delta), .direction(direction), .mode(mode),
    .count(count_b), .current(current_b), .dir_q(dir_q_b),
    .bound_hit(bound_hit_b), .at_max(at_max_b), .at_min(at_min_b)
  );

  function automatic mstate_t reset_state(int lo);
    mstate_t s;
    s.count = lo; s.current = 0; s.dir = 1'b1; s.hit = 1'b0;
    return s;
  endfunction

  // Reference behaviour of one clock edge written from the counting rules.
  function automatic mstate_t model_step(mstate_t s, int lo, int hi, bit ld, int lv,
                                         bit e, int d, bit dr, int md);
    mstate_t n;
    int      raw;
    bit      up;
    bit      bounce;
    n      = s;
    n.hit  = 1'b0;
    bounce = (md == 2);
    if (ld) begin
      n.count   = (lv < lo) ? lo : ((lv > hi) ? hi : lv);
      n.dir     = dr;
      n.current = 0;
      return n;
    end
    if (!e) return n;
    n.current = d;
    up = bounce ? s.dir : dr;
    if (!bounce) n.dir = dr;
    if (d == 0) return n;
    raw = up ? s.count + d : s.count - d;
    if (raw > hi) begin
      n.hit = 1'b1;
      if (md == 0)      n.count = raw - (hi - lo + 1);
      else if (bounce) begin n.count = 2 * hi - raw; n.dir = 1'b0; end
      else              n.count = hi;
    end else if (raw < lo) begin
      n.hit = 1'b1;
      if (md == 0)      n.count = raw + (hi - lo + 1);
      else if (bounce) begin n.count = 2 * lo - raw; n.dir = 1'b1; end
      else              n.count = lo;
    end else begin
      n.count = raw;
      if (bounce && up && raw == hi)   n.dir = 1'b0;
      if (bounce && !up && raw == lo)  n.dir = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ma = reset_state(0);
      mb = reset_state(2);
    end else begin
      ma = model_step(ma, 0, 15, load, int'(load_val), en, int'(delta), direction, int'(mode));
      mb = model_step(mb, 2, 12, load, int'(load_val), en, int'(delta), direction, int'(mode));
    end
  end

  task automatic checkEq(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkEq("a.count",     int'(count_a),     ma.count);
    checkEq("a.current",   int'(current_a),   ma.current);
    checkEq("a.dir_q",     int'(dir_q_a),     int'(ma.dir));
    checkEq("a.bound_hit", int'(bound_hit_a), int'(ma.hit));
    checkEq("a.at_max",    int'(at_max_a),    int'(ma.count == 15));
    checkEq("a.at_min",    int'(at_min_a),    int'(ma.count == 0));
    checkEq("b.count",     int'(count_b),     mb.count);
    checkEq("b.current",   int'(current_b),   mb.current);
    checkEq("b.dir_q",     int'(dir_q_b),     int'(mb.dir));
    checkEq("b.bound_hit", int'(bound_hit_b), int'(mb.hit));
    checkEq("b.at_max",    int'(at_max_b),    int'(mb.count == 12));
    checkEq("b.at_min",    int'(at_min_b),    int'(mb.count == 2));
  endtask

  always @(negedge clk) begin
    if (check_en) checkOutput();
  end

  task automatic applyStimulus(bit ld, int lv, bit e, int d, bit dr, int md);
    load      = ld;
    load_val  = 4'(lv);
    en        = e;
    delta     = 3'(d);
    direction = dr;
    mode      = 2'(md);
    @(posedge clk);
    #1;
  endtask

  int exp_wrap [6] = '{3, 6, 9, 12, 15, 2};
  int exp_bnc  [7] = '{14, 11, 8, 5, 2, 1, 4};
  int hit_bnc  [7] = '{1, 0, 0, 0, 0, 1, 0};
  int dir_bnc  [7] = '{0, 0, 0, 0, 0, 1, 1};

  initial begin
    resetn = 1'b0;
    load = 1'b0; load_val = '0; en = 1'b0; delta = '0; direction = 1'b0; mode = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkEq("reset a.count", int'(count_a), 0);
    checkEq("reset a.dir_q", int'(dir_q_a), 1);
    checkEq("reset a.current", int'(current_a), 0);
    checkEq("reset a.bound_hit", int'(bound_hit_a), 0);
    checkEq("reset b.count", int'(count_b), 2);
    resetn   = 1'b1;
    check_en = 1'b1;

    // Wrap up by 3 from 0.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 1, 3, 1, 0);
      checkEq("wrap up count", int'(count_a), exp_wrap[i]);
      checkEq("wrap up hit", int'(bound_hit_a), (i == 5) ? 1 : 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkEq("idle hit clear", int'(bound_hit_a), 0);
    checkEq("idle count", int'(count_a), 2);

    // Wrap down by 2 from 1.
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 2, 0, 0);
    checkEq("wrap down count", int'(count_a), 15);
    checkEq("wrap down hit", int'(bound_hit_a), 1);
    applyStimulus(0, 0, 1, 2, 0, 0);
    checkEq("wrap down count2", int'(count_a), 13);
    checkEq("wrap down hit2", int'(bound_hit_a), 0);

    // Saturate up from 14.
    applyStimulus(1, 14, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 3, 1, 1);
      checkEq("sat count", int'(count_a), 15);
      checkEq("sat hit", int'(bound_hit_a), 1);
      checkEq("sat at_max", int'(at_max_a), 1);
    end

    // Bounce from 13 going up; direction input is ignored while stepping.
    applyStimulus(1, 13, 0, 0, 1, 2);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 0, 1, 3, 0, 2);
      checkEq("bounce count", int'(count_a), exp_bnc[i]);
      checkEq("bounce hit", int'(bound_hit_a), hit_bnc[i]);
      checkEq("bounce dir", int'(dir_q_a), dir_bnc[i]);
    end
    applyStimulus(1, 12, 0, 0, 1, 2);
    applyStimulus(0, 0, 1, 3, 1, 2);
    checkEq("exact hit count", int'(count_a), 15);
    checkEq("exact hit dir", int'(dir_q_a), 0);
    checkEq("exact hit flag", int'(bound_hit_a), 0);

    // Load/enable collision and clamp on the 2..12 counter.
    applyStimulus(1, 14, 1, 5, 1, 0);
    checkEq("clamp b.count", int'(count_b), 12);
    checkEq("clamp b.current", int'(current_b), 0);
    checkEq("clamp a.count", int'(count_a), 14);
    applyStimulus(0, 0, 1, 0, 1, 2);
    checkEq("zero delta b.count", int'(count_b), 12);
    checkEq("zero delta b.current", int'(current_b), 0);
    checkEq("zero delta b.dir", int'(dir_q_b), 1);

    // Asynchronous reset between edges.
    applyStimulus(1, 9, 0, 0, 0, 0);
    checkEq("pre reset count", int'(count_a), 9);
    #2 resetn = 1'b0;
    #1;
    checkEq("async reset count", int'(count_a), 0);
    checkEq("async reset dir", int'(dir_q_a), 1);
    checkEq("async reset current", int'(current_a), 0);
    checkEq("async reset b.count", int'(count_b), 2);
    resetn = 1'b1;
    applyStimulus(0, 0, 1, 7, 1, 0);
    checkEq("post reset a.count", int'(count_a), 7);
    checkEq("post reset b.count", int'(count_b), 9);

    // Randomised traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 99) == 0) begin
        #1 resetn = 1'b0;
        #1 resetn = 1'b1;
      end
    end

    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
